// File: rtl/pe_2d.sv
// 2x2 output-stationary systolic MAC array: row operands shift right, column
// operands shift down, and each PE accumulates a*b in place (modulo 2^W).

module pe_2d_cell #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] a_q,
  output logic [W-1:0] b_q,
  output logic [W-1:0] acc
);

  logic [2*W-1:0] prod;

  assign prod = a * b;

  // Only the low W bits of the product matter since the sum wraps at 2^W.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
      a_q <= '0;
      b_q <= '0;
    end else if (en) begin
      acc <= acc + prod[W-1:0];
      a_q <= a;
      b_q <= b;
    end
  end

endmodule

module pe_2d #(
  parameter int CONV4_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic [2*CONV4_WIDTH-1:0] i_r1,
  input  logic [2*CONV4_WIDTH-1:0] i_r2,
  output logic [4*CONV4_WIDTH-1:0] o_mat
);

  localparam int W = CONV4_WIDTH;

  logic [W-1:0] a_in [2][2];
  logic [W-1:0] b_in [2][2];
  logic [W-1:0] a_q  [2][2];
  logic [W-1:0] b_q  [2][2];
  logic [W-1:0] acc  [2][2];

  for (genvar r = 0; r < 2; r++) begin : g_row
    for (genvar c = 0; c < 2; c++) begin : g_col
      // Left column takes the edge operand; others take the neighbour's a_q.
      if (c == 0) begin : g_a_edge
        assign a_in[r][c] = i_r1[r*W +: W];
      end else begin : g_a_fwd
        assign a_in[r][c] = a_q[r][c-1];
      end

      if (r == 0) begin : g_b_edge
        assign b_in[r][c] = i_r2[c*W +: W];
      end else begin : g_b_fwd
        assign b_in[r][c] = b_q[r-1][c];
      end

      pe_2d_cell #(.W(W)) u_cell (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .a    (a_in[r][c]),
        .b    (b_in[r][c]),
        .a_q  (a_q[r][c]),
        .b_q  (b_q[r][c]),
        .acc  (acc[r][c])
      );

      assign o_mat[(2*r+c)*W +: W] = acc[r][c];
    end
  end

  // Forwarded values leaving the right and bottom edges have no consumer.
  logic unused_edge_fwd;
  assign unused_edge_fwd = ^{a_q[0][1], a_q[1][1], b_q[1][0], b_q[1][1]};

endmodule

// File: tb/tb_pe_2d.sv
// Directed and randomised bench for the 2x2 systolic MAC array; expected o_mat
// values are queued as stimulus is driven and popped when the output is sampled.

module tb_pe_2d;

  localparam int W = 8;

  logic        clk  = 1'b0;
  logic        rstn = 1'b1;
  logic        en   = 1'b0;
  logic [15:0] i_r1 = '0;
  logic [15:0] i_r2 = '0;
  logic [31:0] o_mat;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  pe_2d #(.CONV4_WIDTH(W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .en    (en),
    .i_r1  (i_r1),
    .i_r2  (i_r2),
    .o_mat (o_mat)
  );

  task automatic apply_reset();
    rstn = 1'b0;
    en   = 1'b0;
    i_r1 = '0;
    i_r2 = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Driver tasks
  task automatic beat(input logic [15:0] r1, input logic [15:0] r2);
    i_r1 = r1;
    i_r2 = r2;
    en   = 1'b1;
    @(posedge clk);
    #1;
    en   = 1'b0;
    i_r1 = '0;
    i_r2 = '0;
  endtask

  task automatic idle_cycle();
    en   = 1'b0;
    i_r1 = 16'($urandom_range(1, 16'hFFFF));
    i_r2 = 16'($urandom_range(1, 16'hFFFF));
    @(posedge clk);
    #1;
    i_r1 = '0;
    i_r2 = '0;
  endtask

  // Scoreboard
  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h but scoreboard queue empty", tag, o_mat);
    end else begin
      e = exp_q.pop_front();
      assert (o_mat === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, o_mat, e);
      end
    end
  endtask

  task automatic step(input logic [15:0] r1, input logic [15:0] r2,
                      input logic [31:0] e, input string tag);
    push_exp(e);
    beat(r1, r2);
    check(tag);
  endtask

  logic [7:0]  ma [2][2];
  logic [7:0]  mb [2][2];
  logic [7:0]  mc [2][2];
  logic [31:0] exp_mat;

  initial begin
    // Test 1: reset with live inputs and en=1
    #2;
    rstn = 1'b0;
    en   = 1'b1;
    i_r1 = 16'hFFFF;
    i_r2 = 16'h1234;
    #1;
    push_exp(32'h0); check("reset_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      push_exp(32'h0); check("reset_held");
    end
    en   = 1'b0;
    rstn = 1'b1;
    #1;
    push_exp(32'h0); check("reset_release");
    @(posedge clk);
    #1;
    push_exp(32'h0); check("reset_en_low_edge");
    i_r1 = '0;
    i_r2 = '0;

    // Test 2: single beat
    apply_reset();
    step(16'h0002, 16'h0003, 32'h0000_0006, "single_beat");
    for (int i = 0; i < 3; i++)
      step(16'h0000, 16'h0000, 32'h0000_0006, "single_zero_tail");

    // Test 3: skewed 2x2 product
    apply_reset();
    step(16'h0001, 16'h0005, 32'h0000_0005, "mat_e1");
    step(16'h0302, 16'h0607, 32'h000F_0613, "mat_e2");
    step(16'h0400, 16'h0800, 32'h122B_1613, "mat_e3");
    step(16'h0000, 16'h0000, 32'h322B_1613, "mat_e4");

    // Test 4: enable hold between beats 2 and 3
    apply_reset();
    step(16'h0001, 16'h0005, 32'h0000_0005, "hold_e1");
    step(16'h0302, 16'h0607, 32'h000F_0613, "hold_e2");
    for (int i = 0; i < 3; i++) begin
      push_exp(32'h000F_0613);
      idle_cycle();
      check("hold_frozen");
    end
    step(16'h0400, 16'h0800, 32'h122B_1613, "hold_e3");
    step(16'h0000, 16'h0000, 32'h322B_1613, "hold_e4");

    // Test 5: truncation and wrap
    apply_reset();
    step(16'h0010, 16'h0010, 32'h0000_0000, "wrap_16x16");
    step(16'h000F, 16'h0011, 32'h0000_00FF, "wrap_15x17");
    step(16'h0001, 16'h0001, 32'h0000_0000, "wrap_roll");

    // Test 6: asynchronous reset between edges mid-product
    apply_reset();
    step(16'h0001, 16'h0005, 32'h0000_0005, "arst_e1");
    step(16'h0302, 16'h0607, 32'h000F_0613, "arst_e2");
    #2;
    rstn = 1'b0;
    #1;
    push_exp(32'h0); check("arst_immediate");
    #1;
    rstn = 1'b1;
    // Remaining beats run on cleared forwarding registers: only 4*8 reaches acc11.
    step(16'h0400, 16'h0800, 32'h0000_0000, "arst_e3");
    step(16'h0000, 16'h0000, 32'h2000_0000, "arst_e4");

    // Randomised products against a plain matrix-multiply model
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          ma[r][c] = 8'($urandom_range(0, 255));
          mb[r][c] = 8'($urandom_range(0, 255));
        end
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++)
          mc[r][c] = 8'((int'(ma[r][0]) * int'(mb[0][c]) +
                         int'(ma[r][1]) * int'(mb[1][c])) % 256);
      exp_mat = {mc[1][1], mc[1][0], mc[0][1], mc[0][0]};
      apply_reset();
      beat({8'h00,    ma[0][0]}, {8'h00,    mb[0][0]});
      beat({ma[1][0], ma[0][1]}, {mb[0][1], mb[1][0]});
      beat({ma[1][1], 8'h00},    {mb[1][1], 8'h00});
      push_exp(exp_mat);
      beat(16'h0000, 16'h0000);
      check("rand_product");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
